micro_sequencer: RTL and testbench

//  Micro-program sequencer for the control unit. Owns the micro-PC (uPC), drives the

---
 rtl/micro_sequencer_if.sv | 31 +++
 rtl/micro_sequencer.sv | 117 +++++++++++
 tb/tb_micro_sequencer.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/micro_sequencer_if.sv
// Sequencer bus: top-level handshake, condition flags, microcode ROM port and control-word output.
// The master side is the controller plus ROM, and the slave side is the sequencer.
interface micro_sequencer_if #(
    parameter int ADDR_W = 16,
    parameter int OPS_W  = 51
);
    logic              start;
    logic              abort;
    logic              stall;
    logic [1:0]        flags;
    logic [ADDR_W-1:0] rom_addr;
    logic [1:0]        condition;
    logic              bt;
    logic [OPS_W-1:0]  ops_in;
    logic [ADDR_W-1:0] jump_addr;
    logic [OPS_W-1:0]  ops_out;
    logic              busy;
    logic              done;
    logic              err;
    logic [15:0]       ucycles;

    modport master (
        output start, abort, stall, flags, condition, bt, ops_in, jump_addr,
        input  rom_addr, ops_out, busy, done, err, ucycles
    );

    modport slave (
        input  start, abort, stall, flags, condition, bt, ops_in, jump_addr,
        output rom_addr, ops_out, busy, done, err, ucycles
    );
endinterface

// File: rtl/micro_sequencer.sv
// Micro-program sequencer: owns the uPC, addresses the combinational microcode ROM,
// resolves branches and registers the control word toward the datapath.
module micro_sequencer #(
    parameter int                ADDR_W     = 16,
    parameter int                OPS_W      = 51,
    parameter logic [ADDR_W-1:0] START_ADDR = '0,
    parameter logic [ADDR_W-1:0] LAST_ADDR  = 16'd240,
    parameter logic [ADDR_W-1:0] HALT_ADDR  = '1
) (
    input logic                 clk,
    input logic                 rst_n,
    micro_sequencer_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] upc, upc_n;
    logic [OPS_W-1:0]  ops_p1, ops_n;
    logic              err, err_n;
    logic [15:0]       ucyc, ucyc_n;
    logic              taken;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic branch_taken(input logic [1:0] cond, input logic sense,
                                          input logic [1:0] fl);
        case (cond)
            2'b01:   return fl[0] == sense;
            2'b10:   return fl[1] == sense;
            2'b11:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    assign taken = branch_taken(bus.condition, bus.bt, bus.flags);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            upc    <= START_ADDR;
            ops_p1 <= '0;
            err    <= 1'b0;
            ucyc   <= '0;
        end else begin
            state  <= state_n;
            upc    <= upc_n;
            ops_p1 <= ops_n;
            err    <= err_n;
            ucyc   <= ucyc_n;
        end
    end

    always_comb begin
        state_n = state;
        upc_n   = upc;
        ops_n   = '0;
        err_n   = err;
        ucyc_n  = ucyc;
        case (state)
            IDLE: begin
                if (bus.abort) begin
                    upc_n = START_ADDR;
                end else if (bus.start) begin
                    upc_n   = START_ADDR;
                    err_n   = 1'b0;
                    ucyc_n  = '0;
                    state_n = RUN;
                end
            end
            RUN: begin
                if (bus.abort) begin
                    upc_n   = START_ADDR;
                    state_n = IDLE;
                end else if (!bus.stall) begin
                    ucyc_n = sat_inc(ucyc);
                    if (taken && bus.jump_addr == HALT_ADDR) begin
                        ops_n   = bus.ops_in;
                        state_n = DONE;
                    end else if (taken) begin
                        ops_n = bus.ops_in;
                        upc_n = bus.jump_addr;
                    // >= also catches a uPC parked beyond the ROM by an out-of-range jump
                    end else if (upc >= LAST_ADDR) begin
                        err_n   = 1'b1;
                        state_n = DONE;
                    end else begin
                        ops_n = bus.ops_in;
                        upc_n = upc + 1'b1;
                    end
                end
            end
            DONE: begin
                upc_n   = START_ADDR;
                state_n = IDLE;
            end
            default: begin
                upc_n   = START_ADDR;
                state_n = IDLE;
            end
        endcase
    end

    assign bus.rom_addr = upc;
    assign bus.ops_out  = ops_p1;
    assign bus.busy     = (state == RUN);
    assign bus.done     = (state == DONE);
    assign bus.err      = err;
    assign bus.ucycles  = ucyc;

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer with a small ROM model held in local arrays.
module tb_micro_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    logic [1:0]  rom_cond [0:255];
    logic        rom_bt   [0:255];
    logic [50:0] rom_ops  [0:255];
    logic [15:0] rom_jump [0:255];

    micro_sequencer_if #(.ADDR_W(16), .OPS_W(51)) bus ();

    micro_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always_comb begin
        bus.condition = 2'b00;
        bus.bt        = 1'b0;
        bus.ops_in    = '0;
        bus.jump_addr = '0;
        if (bus.rom_addr < 16'd256) begin
            bus.condition = rom_cond[bus.rom_addr[7:0]];
            bus.bt        = rom_bt[bus.rom_addr[7:0]];
            bus.ops_in    = rom_ops[bus.rom_addr[7:0]];
            bus.jump_addr = rom_jump[bus.rom_addr[7:0]];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rom_clear();
        for (int i = 0; i < 256; i++) begin
            rom_cond[i] = 2'b00;
            rom_bt[i]   = 1'b0;
            rom_ops[i]  = '0;
            rom_jump[i] = '0;
        end
    endtask

    task automatic load_linear();
        rom_clear();
        for (int i = 0; i < 4; i++) rom_ops[i] = 51'(i + 1);
        rom_cond[4] = 2'b11;
        rom_jump[4] = 16'hFFFF;
        rom_ops[4]  = 51'd5;
    endtask

    task automatic test_reset();
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", bus.busy); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b exp=0", bus.done); end
        total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL reset_err got=%0b exp=0", bus.err); end
        total++; if (bus.ops_out !== 51'd0) begin bad++; $display("FAIL reset_ops got=%0h exp=0", bus.ops_out); end
        total++; if (bus.ucycles !== 16'd0) begin bad++; $display("FAIL reset_ucycles got=%0d exp=0", bus.ucycles); end
        total++; if (bus.rom_addr !== 16'd0) begin bad++; $display("FAIL reset_addr got=%0d exp=0", bus.rom_addr); end
    endtask

    task automatic test_linear();
        load_linear();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL lin_busy got=%0b exp=1", bus.busy); end
        total++; if (bus.rom_addr !== 16'd0) begin bad++; $display("FAIL lin_addr0 got=%0d exp=0", bus.rom_addr); end
        for (int i = 1; i <= 5; i++) begin
            tick();
            total++;
            if (bus.ops_out !== 51'(i)) begin bad++; $display("FAIL lin_ops[%0d] got=%0d exp=%0d", i, bus.ops_out, i); end
        end
        total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL lin_done got=%0b exp=1", bus.done); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL lin_busy_end got=%0b exp=0", bus.busy); end
        tick();
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL lin_done_pulse got=%0b exp=0", bus.done); end
        total++; if (bus.ops_out !== 51'd0) begin bad++; $display("FAIL lin_ops_idle got=%0h exp=0", bus.ops_out); end
        total++; if (bus.ucycles !== 16'd5) begin bad++; $display("FAIL lin_ucycles got=%0d exp=5", bus.ucycles); end
        total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL lin_err got=%0b exp=0", bus.err); end
    endtask

    task automatic test_cond_loop();
        int exp_addr [10] = '{0, 1, 2, 1, 2, 1, 2, 1, 2, 3};
        int vis = 0;
        rom_clear();
        for (int i = 0; i < 4; i++) rom_ops[i] = 51'(16 + i);
        rom_cond[2] = 2'b01; rom_bt[2] = 1'b0; rom_jump[2] = 16'd1;
        rom_cond[3] = 2'b11; rom_jump[3] = 16'hFFFF;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            total++;
            if (bus.rom_addr !== 16'(exp_addr[k])) begin
                bad++; $display("FAIL loop_addr[%0d] got=%0d exp=%0d", k, bus.rom_addr, exp_addr[k]);
            end
            if (bus.rom_addr == 16'd2) begin
                bus.flags = {1'b0, vis >= 3};
                vis++;
            end else begin
                bus.flags = 2'b00;
            end
            tick();
            total++;
            if (bus.ops_out !== 51'(16 + exp_addr[k])) begin
                bad++; $display("FAIL loop_ops[%0d] got=%0h exp=%0h", k, bus.ops_out, 16 + exp_addr[k]);
            end
        end
        bus.flags = 2'b00;
        total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL loop_done got=%0b exp=1", bus.done); end
        total++; if (bus.ucycles !== 16'd10) begin bad++; $display("FAIL loop_ucycles got=%0d exp=10", bus.ucycles); end
        tick();
    endtask

    task automatic test_stall();
        load_linear();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        total++; if (bus.rom_addr !== 16'd2) begin bad++; $display("FAIL stall_pre_addr got=%0d exp=2", bus.rom_addr); end
        bus.stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++; if (bus.rom_addr !== 16'd2) begin bad++; $display("FAIL stall_addr[%0d] got=%0d exp=2", i, bus.rom_addr); end
            total++; if (bus.ops_out !== 51'd0) begin bad++; $display("FAIL stall_nop[%0d] got=%0h exp=0", i, bus.ops_out); end
            total++; if (bus.ucycles !== 16'd2) begin bad++; $display("FAIL stall_ucyc[%0d] got=%0d exp=2", i, bus.ucycles); end
        end
        bus.stall = 1'b0;
        for (int i = 3; i <= 5; i++) begin
            tick();
            total++; if (bus.ops_out !== 51'(i)) begin bad++; $display("FAIL stall_ops[%0d] got=%0d exp=%0d", i, bus.ops_out, i); end
        end
        total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL stall_done got=%0b exp=1", bus.done); end
        total++; if (bus.ucycles !== 16'd5) begin bad++; $display("FAIL stall_ucycles got=%0d exp=5", bus.ucycles); end
        tick();
    endtask

    task automatic test_overrun();
        rom_clear();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 241; i++) begin
            if (i == 240) begin
                total++; if (bus.rom_addr !== 16'd240) begin bad++; $display("FAIL ovr_last_addr got=%0d exp=240", bus.rom_addr); end
                total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL ovr_busy got=%0b exp=1", bus.busy); end
            end
            tick();
        end
        total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL ovr_done got=%0b exp=1", bus.done); end
        total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL ovr_err got=%0b exp=1", bus.err); end
        total++; if (bus.ops_out !== 51'd0) begin bad++; $display("FAIL ovr_ops got=%0h exp=0", bus.ops_out); end
        total++; if (bus.ucycles !== 16'd241) begin bad++; $display("FAIL ovr_ucycles got=%0d exp=241", bus.ucycles); end
        tick();
        total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL ovr_err_sticky got=%0b exp=1", bus.err); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL ovr_done_pulse got=%0b exp=0", bus.done); end
    endtask

    task automatic test_abort_start();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL abort_idle_err got=%0b exp=1", bus.err); end
        total++; if (bus.ucycles !== 16'd241) begin bad++; $display("FAIL abort_idle_ucyc got=%0d exp=241", bus.ucycles); end
        rom_clear();
        for (int i = 0; i < 10; i++) rom_ops[i] = 51'(32 + i);
        rom_cond[10] = 2'b11; rom_jump[10] = 16'hFFFF; rom_ops[10] = 51'h2A;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (5) tick();
        total++; if (bus.rom_addr !== 16'd5) begin bad++; $display("FAIL ab_pre_addr got=%0d exp=5", bus.rom_addr); end
        bus.start = 1'b1;
        bus.abort = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL ab_busy got=%0b exp=0", bus.busy); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL ab_done got=%0b exp=0", bus.done); end
        total++; if (bus.rom_addr !== 16'd0) begin bad++; $display("FAIL ab_addr got=%0d exp=0", bus.rom_addr); end
        total++; if (bus.ops_out !== 51'd0) begin bad++; $display("FAIL ab_ops got=%0h exp=0", bus.ops_out); end
        total++; if (bus.ucycles !== 16'd5) begin bad++; $display("FAIL ab_ucycles got=%0d exp=5", bus.ucycles); end
        total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL ab_err got=%0b exp=0", bus.err); end
        tick();
        total++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin bad++; $display("FAIL ab_stay_idle got=%0b%0b exp=00", bus.busy, bus.done); end
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL rs_busy got=%0b exp=1", bus.busy); end
        total++; if (bus.ucycles !== 16'd0) begin bad++; $display("FAIL rs_ucycles got=%0d exp=0", bus.ucycles); end
        repeat (10) tick();
        total++; if (bus.ops_out !== 51'h29) begin bad++; $display("FAIL rs_ops9 got=%0h exp=29", bus.ops_out); end
        total++; if (bus.rom_addr !== 16'd10) begin bad++; $display("FAIL rs_addr10 got=%0d exp=10", bus.rom_addr); end
        tick();
        total++; if (bus.ops_out !== 51'h2A) begin bad++; $display("FAIL rs_ops10 got=%0h exp=2a", bus.ops_out); end
        total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL rs_done got=%0b exp=1", bus.done); end
        total++; if (bus.ucycles !== 16'd11) begin bad++; $display("FAIL rs_ucycles got=%0d exp=11", bus.ucycles); end
        tick();
    endtask

    task automatic test_async_reset();
        load_linear();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        total++; if (bus.ops_out !== 51'd2) begin bad++; $display("FAIL ar_pre_ops got=%0d exp=2", bus.ops_out); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (bus.ops_out !== 51'd0) begin bad++; $display("FAIL ar_ops got=%0h exp=0", bus.ops_out); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL ar_busy got=%0b exp=0", bus.busy); end
        total++; if (bus.rom_addr !== 16'd0) begin bad++; $display("FAIL ar_addr got=%0d exp=0", bus.rom_addr); end
        total++; if (bus.ucycles !== 16'd0) begin bad++; $display("FAIL ar_ucycles got=%0d exp=0", bus.ucycles); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL ar_done got=%0b exp=0", bus.done); end
        #2;
        rst_n = 1'b1;
        tick();
        total++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin bad++; $display("FAIL ar_after got=%0b%0b exp=00", bus.busy, bus.done); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.stall = 1'b0;
        bus.flags = 2'b00;
        rom_clear();
        rst_n = 1'b0;
        #3;
        test_reset();
        #9;
        rst_n = 1'b1;
        tick();
        test_linear();
        test_cond_loop();
        test_stall();
        test_overrun();
        test_abort_start();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
